// File: rtl/rgb2ycbcr_stream_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb2ycbcr_stream_ctrl_pkg: shared state type and default parameters  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rgb2ycbcr_stream_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ctrlState_t;

   localparam int DEFAULT_LAT    = 3;
   localparam int DEFAULT_DEPTH  = 8;
   localparam int DEFAULT_WIDTH  = 640;
   localparam int DEFAULT_HEIGHT = 480;

   // FIFO entry layout: {Y, Cb, Cr, sof, eol}
   localparam int ENTRY_W = 26;

   function automatic int clogMin1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2ycbcr_stream_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ycbcr_out_fifo: first-word-fall-through output buffer, 26-bit entries |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ycbcr_out_fifo
   import rgb2ycbcr_stream_ctrl_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic                         iWr,
   input  logic [ENTRY_W-1:0]           iData,
   input  logic                         iRd,
   output logic [ENTRY_W-1:0]           oData,
   output logic                         oEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   oCount
);

   localparam int PW = clogMin1(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PW-1:0]      wrPtr;
   logic [PW-1:0]      rdPtr;
   logic [CW-1:0]      count;
   logic               full;
   logic               wrEn;
   logic               rdEn;

   assign full  = (count == CW'(DEPTH));
   assign rdEn  = iRd && (count != '0);
   // A write into a full FIFO is accepted when the head leaves in the same cycle
   assign wrEn  = iWr && (!full || rdEn);

   always_ff @(posedge iClk) begin
      if (wrEn) begin
         mem[wrPtr] <= iData;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrEn) begin
            wrPtr <= (wrPtr == PTR_LAST) ? '0 : wrPtr + 1'b1;
         end
         if (rdEn) begin
            rdPtr <= (rdPtr == PTR_LAST) ? '0 : rdPtr + 1'b1;
         end
         case ({wrEn, rdEn})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign oData  = mem[rdPtr];
   assign oEmpty = (count == '0);
   assign oCount = count;

endmodule
`default_nettype wire

// File: rtl/rgb2ycbcr_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb2ycbcr_stream_ctrl: frame sequencing and credit flow control      |
// | around a fixed-latency RGB->YCbCr core. Rev 1.0                      |
// +----------------------------------------------------------------------+
module rgb2ycbcr_stream_ctrl
   import rgb2ycbcr_stream_ctrl_pkg::*;
#(
   parameter int LAT    = DEFAULT_LAT,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int HEIGHT = DEFAULT_HEIGHT
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iStart,
   input  logic       iValid,
   input  logic [7:0] iR,
   input  logic [7:0] iG,
   input  logic [7:0] iB,
   output logic       oReady,
   output logic       oCe,
   output logic [7:0] oCoreR,
   output logic [7:0] oCoreG,
   output logic [7:0] oCoreB,
   input  logic [7:0] iCoreY,
   input  logic [7:0] iCoreCb,
   input  logic [7:0] iCoreCr,
   output logic       oValid,
   output logic [7:0] oY,
   output logic [7:0] oCb,
   output logic [7:0] oCr,
   output logic       oSof,
   output logic       oEol,
   input  logic       iReady,
   output logic       oBusy,
   output logic       oDone
);

   localparam int XW  = clogMin1(WIDTH);
   localparam int YW  = clogMin1(HEIGHT);
   localparam int IFW = $clog2(LAT + 1);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int SW  = $clog2(DEPTH + LAT + 1);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   ctrlState_t         state;
   ctrlState_t         nextState;
   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic [7:0]         coreR;
   logic [7:0]         coreG;
   logic [7:0]         coreB;
   logic [LAT-1:0]     sbValid;
   logic [LAT-1:0]     sbSof;
   logic [LAT-1:0]     sbEol;
   logic [IFW-1:0]     inflight;
   logic [CW-1:0]      fifoCount;
   logic               fifoEmpty;
   logic [ENTRY_W-1:0] fifoHead;
   logic               headSof;
   logic               headEol;
   logic               active;
   logic               ready;
   logic               upBeat;
   logic               downBeat;
   logic               isSof;
   logic               isEol;
   logic               lastPix;
   logic               done;

   assign active  = !iRst && (state != IDLE);
   assign isSof   = (x == '0) && (y == '0);
   assign isEol   = (x == X_LAST);
   assign lastPix = isEol && (y == Y_LAST);

   // Credit: every accepted pixel owns a FIFO slot from acceptance until it is read
   assign ready    = !iRst && (state == RUN) &&
                     ((SW'(inflight) + SW'(fifoCount)) < SW'(DEPTH));
   assign upBeat   = iValid && ready;
   assign downBeat = iReady && !fifoEmpty && !iRst;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + IFW'(sbValid[i]);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (upBeat && lastPix) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            if ((inflight == '0) && fifoEmpty) begin
               done      = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         x       <= '0;
         y       <= '0;
         coreR   <= '0;
         coreG   <= '0;
         coreB   <= '0;
         sbValid <= '0;
         sbSof   <= '0;
         sbEol   <= '0;
      end else begin
         if (upBeat) begin
            coreR <= iR;
            coreG <= iG;
            coreB <= iB;
            if (isEol) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
         // Sideband moves in lockstep with the core, which only advances on oCe
         if (active) begin
            for (int i = LAT - 1; i > 0; i--) begin
               sbValid[i] <= sbValid[i-1];
               sbSof[i]   <= sbSof[i-1];
               sbEol[i]   <= sbEol[i-1];
            end
            sbValid[0] <= upBeat;
            sbSof[0]   <= upBeat && isSof;
            sbEol[0]   <= upBeat && isEol;
         end
      end
   end

   ycbcr_out_fifo #(
      .DEPTH (DEPTH)
   ) u_outFifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iWr    (sbValid[LAT-1]),
      .iData  ({iCoreY, iCoreCb, iCoreCr, sbSof[LAT-1], sbEol[LAT-1]}),
      .iRd    (downBeat),
      .oData  (fifoHead),
      .oEmpty (fifoEmpty),
      .oCount (fifoCount)
   );

   assign {oY, oCb, oCr, headSof, headEol} = fifoHead;

   assign oReady = ready;
   assign oCe    = active;
   assign oCoreR = iRst ? 8'd0 : coreR;
   assign oCoreG = iRst ? 8'd0 : coreG;
   assign oCoreB = iRst ? 8'd0 : coreB;
   assign oValid = !iRst && !fifoEmpty;
   assign oSof   = !iRst && !fifoEmpty && headSof;
   assign oEol   = !iRst && !fifoEmpty && headEol;
   assign oBusy  = active;
   assign oDone  = !iRst && done;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rgb2ycbcr_stream_ctrl: randomized bench with a pass-through core  |
// | stub and a queue-based reference model. Rev 1.0                      |
// +----------------------------------------------------------------------+
module tb_rgb2ycbcr_stream_ctrl;

   localparam int LAT    = 3;
   localparam int DEPTH  = 8;
   localparam int WIDTH  = 4;
   localparam int HEIGHT = 2;
   localparam int NPIX   = WIDTH * HEIGHT;

   logic       iClk   = 1'b0;
   logic       iRst   = 1'b1;
   logic       iStart = 1'b0;
   logic       iValid = 1'b0;
   logic       iReady = 1'b0;
   logic [7:0] iR     = 8'd0;
   logic [7:0] iG     = 8'd0;
   logic [7:0] iB     = 8'd0;
   logic       oReady, oCe, oValid, oSof, oEol, oBusy, oDone;
   logic [7:0] oCoreR, oCoreG, oCoreB, oY, oCb, oCr;
   logic [7:0] iCoreY, iCoreCb, iCoreCr;

   always #5 iClk = ~iClk;

   rgb2ycbcr_stream_ctrl #(
      .LAT(LAT), .DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart),
      .iValid(iValid), .iR(iR), .iG(iG), .iB(iB), .oReady(oReady),
      .oCe(oCe), .oCoreR(oCoreR), .oCoreG(oCoreG), .oCoreB(oCoreB),
      .iCoreY(iCoreY), .iCoreCb(iCoreCb), .iCoreCr(iCoreCr),
      .oValid(oValid), .oY(oY), .oCb(oCb), .oCr(oCr), .oSof(oSof), .oEol(oEol),
      .iReady(iReady), .oBusy(oBusy), .oDone(oDone)
   );

   // Core stub: Y=R, Cb=G, Cr=B; the controller's input register plus these
   // two CE-gated stages give LAT=3 clocks from acceptance to core output.
   logic [23:0] stage0 = 24'd0;
   logic [23:0] stage1 = 24'd0;
   always @(posedge iClk) begin
      if (oCe) begin
         stage0 <= {oCoreR, oCoreG, oCoreB};
         stage1 <= stage0;
      end
   end
   assign {iCoreY, iCoreCb, iCoreCr} = stage1;

   logic [25:0] outQ[$];
   logic [25:0] expQ[$];
   int cyc = 0, doneCnt = 0, doneCyc = -1, lastOutCyc = -1;
   int checks = 0, errors = 0;
   bit timedOut = 1'b0;

   always @(negedge iClk) begin
      if (!iRst) begin
         if (oValid && iReady) begin
            outQ.push_back({oY, oCb, oCr, oSof, oEol});
            lastOutCyc = cyc;
         end
         if (oDone) begin
            doneCnt++;
            doneCyc = cyc;
         end
      end
      cyc++;
   end

   // Drives whole frames; the model entry for each accepted pixel is {R,G,B,sof,eol}.
   task automatic drive_frames(input int nfr, input int vp, input int rp,
                               input bit noise, input bit fixedPix);
      int k, budget;
      logic [23:0] px;
      for (int f = 0; f < nfr; f++) begin
         iStart = 1'b1;
         @(posedge iClk); #1;
         iStart = 1'b0;
         k = 0;
         budget = 0;
         px = fixedPix ? {8'd115, 8'd78, 8'd98} : 24'($urandom);
         while (k < NPIX && budget < 2000) begin
            iValid = ($urandom_range(99) < vp);
            {iR, iG, iB} = px;
            iReady = ($urandom_range(99) < rp);
            iStart = noise && ($urandom_range(2) == 0);
            @(negedge iClk);
            if (iValid && oReady) begin
               expQ.push_back({px, 1'(k == 0), 1'(k % WIDTH == WIDTH - 1)});
               k++;
               px = fixedPix ? {8'd115, 8'd78, 8'(98 + k)} : 24'($urandom);
            end
            @(posedge iClk); #1;
            budget++;
         end
         iValid = 1'b0;
         while (oBusy && budget < 4000) begin
            iReady = ($urandom_range(99) < rp);
            iStart = noise && (oDone || ($urandom_range(2) == 0));
            @(posedge iClk); #1;
            budget++;
         end
         iStart = 1'b0;
         if (budget >= 4000 || k < NPIX) timedOut = 1'b1;
      end
   endtask

   task automatic test_reset();
      @(negedge iClk);
      checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL rst_oReady: got %b expected 0", oReady); end
      checks++; if (oCe !== 1'b0) begin errors++; $display("FAIL rst_oCe: got %b expected 0", oCe); end
      checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL rst_oValid: got %b expected 0", oValid); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL rst_oBusy: got %b expected 0", oBusy); end
      checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL rst_oDone: got %b expected 0", oDone); end
      checks++; if ({oSof, oEol} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {oSof, oEol}); end
      checks++; if ({oCoreR, oCoreG, oCoreB} !== 24'd0) begin errors++; $display("FAIL rst_core: got %h expected 0", {oCoreR, oCoreG, oCoreB}); end
      @(posedge iClk); #1;
      iRst = 1'b0;
      @(negedge iClk);
      checks++; if ({oBusy, oValid, oReady} !== 3'b000) begin errors++; $display("FAIL idle_outputs: got %b expected 000", {oBusy, oValid, oReady}); end
      @(posedge iClk); #1;
   endtask

   task automatic test_basic();
      int d0;
      outQ.delete(); expQ.delete(); timedOut = 1'b0; d0 = doneCnt;
      drive_frames(1, 100, 100, 1'b0, 1'b1);
      checks++; if (timedOut) begin errors++; $display("FAIL basic_timeout: got timeout expected completion"); end
      checks++; if (outQ.size() != NPIX) begin errors++; $display("FAIL basic_count: got %0d expected %0d", outQ.size(), NPIX); end
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
         checks++;
         if (outQ[i] !== expQ[i]) begin errors++; $display("FAIL basic_pix[%0d]: got %h expected %h", i, outQ[i], expQ[i]); end
      end
      checks++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", doneCnt - d0); end
      checks++; if (doneCyc != lastOutCyc + 1) begin errors++; $display("FAIL basic_done_timing: got %0d expected %0d", doneCyc, lastOutCyc + 1); end
   endtask

   task automatic test_backpressure();
      int k, budget;
      logic [23:0] px;
      outQ.delete(); expQ.delete();
      iReady = 1'b0;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      k = 0;
      px = 24'($urandom);
      for (int c = 0; c < 30; c++) begin
         iValid = 1'b1;
         {iR, iG, iB} = px;
         @(negedge iClk);
         if (iValid && oReady) begin
            expQ.push_back({px, 1'(k == 0), 1'(k % WIDTH == WIDTH - 1)});
            k++;
            px = 24'($urandom);
         end
         @(posedge iClk); #1;
      end
      iValid = 1'b0;
      checks++; if (k != DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", k, DEPTH); end
      checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL bp_oReady: got %b expected 0", oReady); end
      checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL bp_oValid: got %b expected 1", oValid); end
      checks++; if (outQ.size() != 0) begin errors++; $display("FAIL bp_no_output: got %0d expected 0", outQ.size()); end
      iReady = 1'b1;
      budget = 0;
      while (oBusy && budget < 200) begin
         @(posedge iClk); #1;
         budget++;
      end
      checks++; if (budget >= 200) begin errors++; $display("FAIL bp_timeout: got timeout expected idle"); end
      checks++; if (outQ.size() != expQ.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", outQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
         checks++;
         if (outQ[i] !== expQ[i]) begin errors++; $display("FAIL bp_pix[%0d]: got %h expected %h", i, outQ[i], expQ[i]); end
      end
   endtask

   task automatic test_random();
      int d0;
      outQ.delete(); expQ.delete(); timedOut = 1'b0; d0 = doneCnt;
      drive_frames(3, 50, 50, 1'b0, 1'b0);
      checks++; if (timedOut) begin errors++; $display("FAIL rand_timeout: got timeout expected completion"); end
      checks++; if (outQ.size() != 3 * NPIX) begin errors++; $display("FAIL rand_count: got %0d expected %0d", outQ.size(), 3 * NPIX); end
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
         checks++;
         if (outQ[i] !== expQ[i]) begin errors++; $display("FAIL rand_pix[%0d]: got %h expected %h", i, outQ[i], expQ[i]); end
      end
      checks++; if (doneCnt - d0 != 3) begin errors++; $display("FAIL rand_done: got %0d expected 3", doneCnt - d0); end
   endtask

   task automatic test_reset_midframe();
      int k, d0, budget;
      logic [23:0] px;
      outQ.delete(); expQ.delete(); timedOut = 1'b0; d0 = doneCnt;
      iReady = 1'b0;
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
      k = 0;
      budget = 0;
      while (k < 5 && budget < 100) begin
         iValid = 1'b1;
         {iR, iG, iB} = 24'($urandom);
         @(negedge iClk);
         if (iValid && oReady) k++;
         @(posedge iClk); #1;
         budget++;
      end
      iValid = 1'b0;
      iRst = 1'b1;
      @(posedge iClk); #1;
      iRst = 1'b0;
      iReady = 1'b1;
      checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL mid_oValid: got %b expected 0", oValid); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL mid_oBusy: got %b expected 0", oBusy); end
      checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL mid_oReady: got %b expected 0", oReady); end
      repeat (5) @(posedge iClk);
      #1;
      checks++; if (doneCnt != d0 || outQ.size() != 0) begin errors++; $display("FAIL mid_discard: got done=%0d out=%0d expected done=%0d out=0", doneCnt, outQ.size(), d0); end
      px = 24'd0;
      drive_frames(1, 80, 80, 1'b0, 1'b0);
      checks++; if (timedOut) begin errors++; $display("FAIL mid_timeout: got timeout expected completion"); end
      checks++; if (outQ.size() != NPIX) begin errors++; $display("FAIL mid_count: got %0d expected %0d", outQ.size(), NPIX); end
      if (outQ.size() > 0) begin
         px = outQ[0][25:2];
         checks++; if (outQ[0][1] !== 1'b1) begin errors++; $display("FAIL mid_first_sof: got %b expected 1 (pixel %h)", outQ[0][1], px); end
      end
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
         checks++;
         if (outQ[i] !== expQ[i]) begin errors++; $display("FAIL mid_pix[%0d]: got %h expected %h", i, outQ[i], expQ[i]); end
      end
   endtask

   task automatic test_start_ignored();
      int d0;
      outQ.delete(); expQ.delete(); timedOut = 1'b0; d0 = doneCnt;
      drive_frames(1, 70, 70, 1'b1, 1'b0);
      checks++; if (timedOut) begin errors++; $display("FAIL start_timeout: got timeout expected completion"); end
      checks++; if (outQ.size() != NPIX) begin errors++; $display("FAIL start_count: got %0d expected %0d", outQ.size(), NPIX); end
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++) begin
         checks++;
         if (outQ[i] !== expQ[i]) begin errors++; $display("FAIL start_pix[%0d]: got %h expected %h", i, outQ[i], expQ[i]); end
      end
      checks++; if (doneCnt - d0 != 1) begin errors++; $display("FAIL start_done: got %0d expected 1", doneCnt - d0); end
      repeat (3) @(posedge iClk);
      #1;
      checks++; if ({oBusy, oCe, oReady} !== 3'b000) begin errors++; $display("FAIL start_idle: got %b expected 000", {oBusy, oCe, oReady}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_reset_midframe();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion expected finish");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire

// File: doc/rgb2ycbcr_stream_ctrl.md
RGB2YCBCR_STREAM_CTRL -- requirements
Module: rgb2ycbcr_stream_ctrl

Interface
REQ-001 Parameter LAT, default 3: fixed pipeline latency of the rgb2ycbcr core, in clocks with oCe=1.
REQ-002 Parameter DEPTH, default 8: output FIFO entries; SHALL be >= LAT+1.
REQ-003 Parameter WIDTH, default 640: pixels per line.
REQ-004 Parameter HEIGHT, default 480: lines per frame.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 iClk  in  1  sole clock; all state updates on its rising edge.
REQ-007 iRst  in  1  synchronous, active-high reset.
REQ-008 iStart  in  1  one-cycle frame start request.
REQ-009 iValid, iR, iG, iB  in  1/8/8/8  upstream pixel; oReady  out  1  upstream accept.
REQ-010 oCe, oCoreR, oCoreG, oCoreB  out  1/8/8/8  drive the core's iCe, iR, iG, iB.
REQ-011 iCoreY, iCoreCb, iCoreCr  in  8/8/8  core outputs (core oR/oG/oB).
REQ-012 oValid, oY, oCb, oCr, oSof, oEol  out  1/8/8/8/1/1  downstream pixel and frame flags; iReady  in  1  downstream accept.
REQ-013 oBusy  out  1  high outside IDLE; oDone  out  1  one-cycle end-of-frame pulse.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN.
REQ-015 IDLE->RUN on iStart; iStart outside IDLE SHALL be ignored.
REQ-016 Transfer: upstream beat = iValid&oReady; downstream beat = oValid&iReady.
REQ-017 oReady = (state==RUN) & (inflight + fifo_count < DEPTH), combinational.
REQ-018 oCe = 1 in RUN and DRAIN, 0 in IDLE; core inputs register upstream RGB on each upstream beat, hold otherwise.
REQ-019 A LAT-stage sideband shift register, advanced whenever oCe=1, carries {valid, sof, eol}; valid=1 at entry only on an upstream beat.
REQ-020 When the sideband tap at stage LAT is valid, {iCoreY, iCoreCb, iCoreCr, sof, eol} SHALL be written to the FIFO that cycle; credit rule REQ-017 guarantees no overflow.
REQ-021 inflight = count of valid sideband stages, range 0..LAT.
REQ-022 Position counters x (0..WIDTH-1), y (0..HEIGHT-1) advance per upstream beat; x wraps to 0 and y increments at x=WIDTH-1.
REQ-023 sof tagged when x=0 and y=0; eol tagged when x=WIDTH-1.
REQ-024 RUN->DRAIN on the upstream beat at x=WIDTH-1, y=HEIGHT-1; counters return to 0.
REQ-025 DRAIN->IDLE when inflight=0, FIFO empty and no write pending; oDone=1 for exactly that cycle.
REQ-026 oValid = FIFO not empty; oY/oCb/oCr/oSof/oEol = FIFO head (first-word-fall-through).
REQ-027 Simultaneous FIFO write and read SHALL both proceed; count unchanged; full-and-read-and-write is legal.
REQ-028 Pixel order SHALL be preserved end to end; no pixel dropped or duplicated under any iReady pattern.

Reset
REQ-029 On iRst: state=IDLE; x=y=0; sideband cleared; FIFO emptied.
REQ-030 Output values under reset: oReady=0, oCe=0, oValid=0, oBusy=0, oDone=0, oSof=0, oEol=0, oCoreR/G/B=0.
REQ-031 Reset mid-frame SHALL discard all in-flight and buffered pixels; no oDone issued.

Structure
REQ-032 Shared package holds the state enum and default LAT/DEPTH/WIDTH/HEIGHT constants.
REQ-033 The output FIFO SHALL be a sub-module named ycbcr_out_fifo (parameter DEPTH, 26-bit entry).

Verification (bench uses a core stub: LAT-cycle CE-gated delay, Y=R, Cb=G, Cr=B)
REQ-034 WIDTH=4, HEIGHT=2; iStart; 8 pixels with R=115, G=78, B=98+i, iReady=1 -> 8 outputs in order; Cr=98..105; oSof on first; oEol on 4th and 8th; oDone one cycle after last output.
REQ-035 iReady=0 with continuous iValid -> exactly DEPTH pixels accepted, then oReady=0; FIFO holds DEPTH; iReady=1 resumes with no loss.
REQ-036 Random iValid/iReady at 50% over 3 frames -> output sequence matches input; oDone count=3.
REQ-037 iRst asserted after pixel 5 of 8 -> next cycle oValid=0, oBusy=0, oReady=0; new iStart gives oSof on the first new pixel.
REQ-038 iStart pulsed during RUN and DRAIN -> no effect; iStart in same cycle as oDone -> ignored, state IDLE.
